// File: rtl/lsu_mem_if.sv
// Load/store memory interface stage: one request at a time, word-aligned req/gnt/rvalid bus,
// raw load word returned with address low bits and funct3 for downstream extraction.
module lsu_mem_if #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TO_W           = 5
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,

    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_word,
    output logic [1:0]  rsp_addr_end,
    output logic [2:0]  rsp_funct3,
    output logic        rsp_err,

    output logic        misalign_err,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StRsp} state_e;

    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

    state_e          state_q;
    logic [TO_W-1:0] to_cnt_q;

    logic        misaligned;
    logic [3:0]  wmask_n;
    logic [31:0] wdata_n;

    // Decode of the incoming request; funct3[1:0] selects byte, half or word access.
    always_comb begin
        misaligned = 1'b0;
        wmask_n    = 4'b0000;
        wdata_n    = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                wmask_n = 4'b0001 << req_addr[1:0];
                wdata_n = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                wmask_n    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_n    = {2{req_wdata[15:0]}};
            end
            default: begin
                misaligned = |req_addr[1:0];
                wmask_n    = 4'b1111;
            end
        endcase
        if (!req_we) begin
            wmask_n = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            to_cnt_q     <= '0;
            req_ready    <= 1'b1;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wmask    <= '0;
            mem_wdata    <= '0;
            rsp_valid    <= 1'b0;
            rsp_word     <= '0;
            rsp_addr_end <= '0;
            rsp_funct3   <= '0;
            rsp_err      <= 1'b0;
            misalign_err <= 1'b0;
            busy         <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        if (misaligned) begin
                            misalign_err <= 1'b1;
                        end else begin
                            state_q      <= StReq;
                            req_ready    <= 1'b0;
                            busy         <= 1'b1;
                            mem_req      <= 1'b1;
                            mem_addr     <= {req_addr[31:2], 2'b00};
                            mem_we       <= req_we;
                            mem_wmask    <= wmask_n;
                            mem_wdata    <= wdata_n;
                            rsp_addr_end <= req_addr[1:0];
                            rsp_funct3   <= req_funct3;
                        end
                    end
                end
                StReq: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state_q   <= StIdle;
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_wmask <= '0;
                        end else begin
                            state_q  <= StWait;
                            to_cnt_q <= '0;
                        end
                    end
                end
                StWait: begin
                    // Data arriving on the final timeout cycle still wins over the error.
                    if (mem_rvalid) begin
                        state_q   <= StRsp;
                        rsp_valid <= 1'b1;
                        rsp_word  <= mem_rdata;
                        rsp_err   <= 1'b0;
                    end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_q == ToLast)) begin
                        state_q   <= StRsp;
                        rsp_valid <= 1'b1;
                        rsp_word  <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                StRsp: begin
                    if (rsp_ready) begin
                        state_q   <= StIdle;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed plus randomized bench for lsu_mem_if; expected bus and response values come from a
// transaction-level model of the load/store rules.
module tb_lsu_mem_if;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        rsp_valid, rsp_ready, rsp_err, misalign_err, busy;
    logic [31:0] rsp_word;
    logic [1:0]  rsp_addr_end;
    logic [2:0]  rsp_funct3;

    int checks = 0;
    int failures = 0;

    lsu_mem_if #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_word(rsp_word),
        .rsp_addr_end(rsp_addr_end), .rsp_funct3(rsp_funct3), .rsp_err(rsp_err),
        .misalign_err(misalign_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr, input logic [2:0] f3);
        return (addr % acc_size(f3)) != 0;
    endfunction

    function automatic void store_model(input logic [31:0] addr, input logic [2:0] f3,
                                        input logic [31:0] wd,
                                        output logic [3:0] m, output logic [31:0] d);
        int unsigned off = addr % 4;
        if (acc_size(f3) == 1) begin
            m = 4'(1 << off);
            d = (wd & 32'hFF) * 32'h0101_0101;
        end else if (acc_size(f3) == 2) begin
            m = 4'(3 << off);
            d = (wd & 32'hFFFF) * 32'h0001_0001;
        end else begin
            m = 4'hF;
            d = wd;
        end
    endfunction

    task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_misaligned(input logic we, input logic [31:0] addr, input logic [2:0] f3);
        issue(we, addr, f3, $urandom);
        chk("mis_pulse", misalign_err, 1);
        chk("mis_no_req", mem_req, 0);
        chk("mis_ready", req_ready, 1);
        chk("mis_busy", busy, 0);
        tick();
        chk("mis_pulse_end", misalign_err, 0);
        chk("mis_no_req2", mem_req, 0);
        chk("mis_no_rsp", rsp_valid, 0);
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                             input int gnt_d);
        logic [3:0]  em;
        logic [31:0] ed;
        store_model(addr, f3, wd, em, ed);
        issue(1'b1, addr, f3, wd);
        for (int i = 0; i <= gnt_d; i++) begin
            chk("st_req", mem_req, 1);
            chk("st_addr", mem_addr, addr & ~32'h3);
            chk("st_we", mem_we, 1);
            chk("st_mask", mem_wmask, em);
            chk("st_wdata", mem_wdata, ed);
            chk("st_ready", req_ready, 0);
            if (i < gnt_d) tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("st_done_ready", req_ready, 1);
        chk("st_done_req", mem_req, 0);
        chk("st_no_rsp", rsp_valid, 0);
    endtask

    task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rd,
                            input int gnt_d, input int rv_d, input int rdy_d, input bit rst_in_rsp);
        logic [31:0] ew;
        logic        ee;
        issue(1'b0, addr, f3, $urandom);
        for (int i = 0; i <= gnt_d; i++) begin
            chk("ld_req", mem_req, 1);
            chk("ld_addr", mem_addr, addr & ~32'h3);
            chk("ld_we", mem_we, 0);
            chk("ld_mask", mem_wmask, 0);
            chk("ld_ready", req_ready, 0);
            if (i < gnt_d) tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        if (rv_d < int'(TO)) begin
            for (int i = 0; i < rv_d; i++) begin
                chk("ld_wait_rsp", rsp_valid, 0);
                chk("ld_wait_req", mem_req, 0);
                tick();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            ew = rd;
            ee = 1'b0;
        end else begin
            for (int i = 0; i < int'(TO); i++) begin
                chk("ld_to_wait", rsp_valid, 0);
                tick();
            end
            ew = 32'h0;
            ee = 1'b1;
        end
        for (int i = 0; i <= rdy_d; i++) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_word", rsp_word, ew);
            chk("rsp_addr_end", rsp_addr_end, addr % 4);
            chk("rsp_funct3", rsp_funct3, f3);
            chk("rsp_err", rsp_err, ee);
            chk("rsp_req_ready", req_ready, 0);
            if (i < rdy_d) tick();
        end
        if (rst_in_rsp) begin
            do_reset();
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_ready", req_ready, 1);
            chk("rst_busy", busy, 0);
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hCAFE_F00D;
            tick();
            mem_rvalid = 1'b0;
            chk("late_rvalid_rsp", rsp_valid, 0);
            chk("late_rvalid_busy", busy, 0);
        end else begin
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk("rsp_done_valid", rsp_valid, 0);
            chk("rsp_done_ready", req_ready, 1);
        end
    endtask

    task automatic random_txn();
        logic        we = 1'($urandom_range(0, 1));
        logic [2:0]  f3;
        logic [31:0] addr = $urandom;
        int          sel;
        if (we) begin
            f3 = 3'($urandom_range(0, 2));
        end else begin
            sel = $urandom_range(0, 4);
            f3  = (sel < 3) ? 3'(sel) : 3'(sel + 1);
        end
        if (is_misaligned(addr, f3)) begin
            run_misaligned(we, addr, f3);
        end else if (we) begin
            run_store(addr, f3, $urandom, $urandom_range(0, 3));
        end else begin
            run_load(addr, f3, $urandom, $urandom_range(0, 3), $urandom_range(0, 18),
                     $urandom_range(0, 3), 1'b0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        rsp_ready  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        chk("reset_ready", req_ready, 1);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_misalign", misalign_err, 0);
        chk("reset_busy", busy, 0);
        chk("reset_wmask", mem_wmask, 0);

        // Minimum-latency LW
        run_load(32'h100, 3'd2, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
        run_store(32'h203, 3'd0, 32'h0000_00A5, 0);
        run_store(32'h202, 3'd1, 32'h0000_1234, 3);
        run_misaligned(1'b0, 32'h101, 3'd1);
        // LBU with no rvalid: timeout
        run_load(32'h302, 3'd4, 32'h0, 0, 99, 0, 1'b0);
        // rvalid on the last timeout cycle returns data
        run_load(32'h404, 3'd2, 32'h1357_9BDF, 1, int'(TO) - 1, 0, 1'b0);
        // Response stalled 5 cycles, then reset mid-RSP
        run_load(32'h501, 3'd0, 32'h8765_4321, 0, 2, 5, 1'b1);

        // Stray gnt in IDLE is ignored
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("idle_gnt_busy", busy, 0);
        chk("idle_gnt_req", mem_req, 0);

        // Reset during WAIT discards the load
        issue(1'b0, 32'h600, 3'd2, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        do_reset();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        tick();
        chk("wait_rst_rsp", rsp_valid, 0);
        chk("wait_rst_ready", req_ready, 1);

        for (int n = 0; n < 40; n++) begin
            random_txn();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
